// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache -- direct-mapped instruction cache, one 32-bit word per line.
//
// Sits between instruction fetch and the memory interface's instruction
// port. Hits answer fetch in the same cycle. A miss issues a single word
// read and waits as long as memory needs. The returned word fills the line
// and is forwarded straight to fetch. A pipeline flush cancels the forward,
// but a read that is already in flight is always completed and still fills
// the line.
//
// Optional feature: define ICACHE_PERF_EN to build the hit/miss performance
// counters. Without it, perf_hit and perf_miss are tied to zero.
//
// Ports
//   clk_in       system clock
//   rst_in       synchronous, active-high reset
//   rdy_in       global ready; when low, all state holds and fetch_ready is 0
//   rob_clear    pipeline flush
//   fetch_valid  fetch request, held with fetch_addr until fetch_ready/flush
//   fetch_addr   fetch byte address (bits [1:0] ignored)
//   fetch_ready  one-cycle pulse: fetch_inst is valid for fetch_addr
//   fetch_inst   instruction word (0 when fetch_ready is low)
//   inst_valid   memory read request (registered)
//   inst_addr    word-aligned memory read address (registered)
//   inst_ready   one-cycle pulse: inst_result is valid
//   inst_result  memory read data
//   perf_hit     hit counter (0 unless ICACHE_PERF_EN)
//   perf_miss    miss counter (0 unless ICACHE_PERF_EN)
// ---------------------------------------------------------------------------
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] fetch_inst,
  output logic        inst_valid,
  output logic [31:0] inst_addr,
  input  logic        inst_ready,
  input  logic [31:0] inst_result,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MISS  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Registered control state
  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       inst_addr_q, inst_addr_d;

  // Line storage: tags and data carry no reset, only the valid bits do.
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  // Address split for the fetch request and for the outstanding miss
  logic [INDEX_BITS-1:0] f_idx, m_idx;
  logic [TAG_W-1:0]      f_tag, m_tag;
  logic                  hit;
  logic                  fill;
  logic                  fetch_ready_c;
  logic [31:0]           fetch_inst_c;

  assign f_idx = fetch_addr[INDEX_BITS+1:2];
  assign f_tag = fetch_addr[31:INDEX_BITS+2];
  assign m_idx = miss_addr_q[INDEX_BITS+1:2];
  assign m_tag = miss_addr_q[31:INDEX_BITS+2];

  assign hit = fetch_valid && valid_q[f_idx] && (tag_mem[f_idx] == f_tag);

  // Byte-offset bits of the fetch address select nothing in a word cache.
  logic unused_fetch_lsb;
  assign unused_fetch_lsb = ^fetch_addr[1:0];

  // -------------------------------------------------------------------------
  // Next-state logic. Every default holds the current value, so gating the
  // whole case on rdy_in is enough to freeze state, array and counters.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    miss_addr_d   = miss_addr_q;
    inst_addr_d   = inst_addr_q;
    fill          = 1'b0;
    fetch_ready_c = 1'b0;
    fetch_inst_c  = 32'd0;

    if (rdy_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (hit && !rob_clear) begin
            fetch_ready_c = 1'b1;
            fetch_inst_c  = data_mem[f_idx];
          end else if (fetch_valid && !hit && !rob_clear) begin
            miss_addr_d = {fetch_addr[31:2], 2'b00};
            inst_addr_d = {fetch_addr[31:2], 2'b00};
            state_d     = S_MISS;
          end
        end

        S_MISS: begin
          if (inst_ready) begin
            fill    = 1'b1;
            state_d = S_IDLE;
            // Forward only if fetch is still asking for the missed word.
            if (fetch_valid && (fetch_addr[31:2] == miss_addr_q[31:2]) &&
                !rob_clear) begin
              fetch_ready_c = 1'b1;
              fetch_inst_c  = inst_result;
            end
          end else if (rob_clear) begin
            // Keep the read alive; its data still fills the line later.
            state_d = S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (inst_ready) begin
            fill    = 1'b1;
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    if (fill) valid_d[m_idx] = 1'b1;

    // The request is registered: it rises the cycle after the miss is taken
    // and drops the cycle after inst_ready.
    inst_valid_d = (state_d != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      miss_addr_q  <= 32'd0;
      inst_valid_q <= 1'b0;
      inst_addr_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_addr_q  <= miss_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_addr_q  <= inst_addr_d;
    end
  end

  // Line fill; a fill arriving in a reset cycle is dropped with the miss.
  always_ff @(posedge clk_in) begin
    if (!rst_in && fill) begin
      tag_mem[m_idx]  <= m_tag;
      data_mem[m_idx] <= inst_result;
    end
  end

  assign fetch_ready = fetch_ready_c;
  assign fetch_inst  = fetch_inst_c;
  assign inst_valid  = inst_valid_q;
  assign inst_addr   = inst_addr_q;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_hit_d;
  logic [31:0] perf_miss_q, perf_miss_d;

  always_comb begin
    perf_hit_d  = perf_hit_q;
    perf_miss_d = perf_miss_q;
    // fetch_ready_c already folds in rdy_in and rob_clear.
    if (state_q == S_IDLE && fetch_ready_c) perf_hit_d = perf_hit_q + 32'd1;
    if (state_q == S_IDLE && state_d == S_MISS) perf_miss_d = perf_miss_q + 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_hit_q  <= 32'd0;
      perf_miss_q <= 32'd0;
    end else begin
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`else
  assign perf_hit  = 32'd0;
  assign perf_miss = 32'd0;
`endif

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, fetch_valid, inst_ready;
  logic [31:0] fetch_addr, inst_result;
  logic        fetch_ready, inst_valid;
  logic [31:0] fetch_inst, inst_addr, perf_hit, perf_miss;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  icache #(.INDEX_BITS(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_inst(fetch_inst),
    .inst_valid(inst_valid), .inst_addr(inst_addr),
    .inst_ready(inst_ready), .inst_result(inst_result),
    .perf_hit(perf_hit), .perf_miss(perf_miss)
  );

`ifdef ICACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected counter value: the count itself when counters exist, else 0.
  function automatic logic [31:0] pc(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  typedef struct {
    logic        fv;
    logic [31:0] fa;
    logic        rc;
    logic        ir;
    logic [31:0] ires;
    logic        rdy;
    logic        efr;
    logic [31:0] efi;
    logic        eiv;
    logic [31:0] eia;
    logic [31:0] eph;
    logic [31:0] epm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic fv, input logic [31:0] fa, input logic rc,
                     input logic ir, input logic [31:0] ires, input logic rdy,
                     input logic efr, input logic [31:0] efi, input logic eiv,
                     input logic [31:0] eia, input int ph, input int pm);
    vec_t v;
    v.fv = fv; v.fa = fa; v.rc = rc; v.ir = ir; v.ires = ires; v.rdy = rdy;
    v.efr = efr; v.efi = efi; v.eiv = eiv; v.eia = eia;
    v.eph = pc(ph); v.epm = pc(pm);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle 1ns later,
  // well away from the rising edge that commits the cycle.
  task automatic drive(input logic rst, input logic rdy, input logic fv,
                       input logic [31:0] fa, input logic rc, input logic ir,
                       input logic [31:0] ires);
    @(negedge clk_in);
    rst_in = rst; rdy_in = rdy; fetch_valid = fv; fetch_addr = fa;
    rob_clear = rc; inst_ready = ir; inst_result = ires;
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic efr,
                          input logic [31:0] efi, input logic eiv,
                          input logic [31:0] eia);
    chk({tag, " fetch_ready"}, 32'(fetch_ready), 32'(efr));
    chk({tag, " fetch_inst"},  fetch_inst, efi);
    chk({tag, " inst_valid"},  32'(inst_valid), 32'(eiv));
    chk({tag, " inst_addr"},   inst_addr, eia);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; fetch_valid = 1'b0;
    fetch_addr = 32'd0; inst_ready = 1'b0; inst_result = 32'd0;

    // Columns: fv fa rc ir ires rdy | fr fi iv ia ph pm (values before edge)
    // Cold miss on 0x100, memory answers 3 cycles after inst_valid, then hit.
    add(1, 32'h100, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,   0, 0);
    add(1, 32'h100, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100, 0, 1);
    add(1, 32'h100, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100, 0, 1);
    add(1, 32'h100, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100, 0, 1);
    add(1, 32'h100, 0, 1, 32'h00500093, 1, 1, 32'h00500093, 1, 32'h100, 0, 1);
    add(1, 32'h100, 0, 0, 32'h0,        1, 1, 32'h00500093, 0, 32'h100, 0, 1);
    // Conflict: 0x200 shares index 0 with 0x100, then 0x100 misses again.
    add(1, 32'h200, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h100, 1, 1);
    add(1, 32'h200, 0, 1, 32'hAAAA0001, 1, 1, 32'hAAAA0001, 1, 32'h200, 1, 2);
    add(1, 32'h100, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h200, 1, 2);
    add(1, 32'h100, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100, 1, 3);
    add(1, 32'h100, 0, 1, 32'h00500093, 1, 1, 32'h00500093, 1, 32'h100, 1, 3);
    // Flush mid-miss on 0x40: drain, no forward, line still filled.
    add(1, 32'h40,  0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h100, 1, 3);
    add(1, 32'h40,  1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h40,  1, 4);
    add(0, 32'h0,   0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h40,  1, 4);
    add(0, 32'h0,   1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h40,  1, 4);
    add(0, 32'h0,   0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h40,  1, 4);
    add(1, 32'h40,  0, 1, 32'h11112222, 1, 0, 32'h0,        1, 32'h40,  1, 4);
    add(1, 32'h40,  0, 0, 32'h0,        1, 1, 32'h11112222, 0, 32'h40,  1, 4);
    // rdy_in low for 5 cycles with a hit pending, then released.
    for (int i = 0; i < 5; i++)
      add(1, 32'h100, 0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h40,  2, 4);
    add(1, 32'h100, 0, 0, 32'h0,        1, 1, 32'h00500093, 0, 32'h40,  2, 4);
    // Flush on a hit in IDLE: no response.
    add(1, 32'h100, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h40,  3, 4);
    // Flush together with inst_ready: fill, no forward.
    add(1, 32'h300, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h40,  3, 4);
    add(1, 32'h300, 1, 1, 32'h33334444, 1, 0, 32'h0,        1, 32'h300, 3, 5);
    add(1, 32'h300, 0, 0, 32'h0,        1, 1, 32'h33334444, 0, 32'h300, 3, 5);
    // Byte offset ignored; a stray inst_ready in IDLE does nothing.
    add(1, 32'h302, 0, 0, 32'h0,        1, 1, 32'h33334444, 0, 32'h300, 4, 5);
    add(0, 32'h0,   0, 1, 32'hDEADBEEF, 1, 0, 32'h0,        0, 32'h300, 5, 5);

    // Reset state
    drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
    chk_outs("reset", 0, 32'h0, 0, 32'h0);
    chk("reset perf_hit", perf_hit, 32'd0);
    chk("reset perf_miss", perf_miss, 32'd0);

    foreach (tbl[i]) begin
      drive(0, tbl[i].rdy, tbl[i].fv, tbl[i].fa, tbl[i].rc, tbl[i].ir,
            tbl[i].ires);
      chk_outs($sformatf("row%0d", i), tbl[i].efr, tbl[i].efi, tbl[i].eiv,
               tbl[i].eia);
      chk($sformatf("row%0d perf_hit", i), perf_hit, tbl[i].eph);
      chk($sformatf("row%0d perf_miss", i), perf_miss, tbl[i].epm);
    end

    // Stalled memory: inst_ready withheld 20 cycles.
    drive(0, 1, 1, 32'h500, 0, 0, 32'h0);
    chk_outs("stall accept", 0, 32'h0, 0, 32'h300);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 1, 32'h500, 0, 0, 32'h0);
      chk_outs($sformatf("stall%0d", i), 0, 32'h0, 1, 32'h500);
    end
    drive(0, 1, 1, 32'h500, 0, 1, 32'h55AA55AA);
    chk_outs("stall done", 1, 32'h55AA55AA, 1, 32'h500);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
    chk_outs("stall idle", 0, 32'h0, 0, 32'h500);
    chk("stall perf_hit", perf_hit, pc(5));
    chk("stall perf_miss", perf_miss, pc(6));

    // Reset during MISS.
    drive(0, 1, 1, 32'h600, 0, 0, 32'h0);
    chk_outs("rmiss accept", 0, 32'h0, 0, 32'h500);
    drive(0, 1, 1, 32'h600, 0, 0, 32'h0);
    chk_outs("rmiss pending", 0, 32'h0, 1, 32'h600);
    drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
    drive(0, 1, 0, 32'h0, 0, 1, 32'hDEADBEEF);
    chk_outs("rmiss after reset", 0, 32'h0, 0, 32'h0);
    chk("rmiss perf_hit", perf_hit, 32'd0);
    chk("rmiss perf_miss", perf_miss, 32'd0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
    chk_outs("rmiss late ready", 0, 32'h0, 0, 32'h0);
    drive(0, 1, 1, 32'h40, 0, 0, 32'h0);
    chk_outs("rmiss 0x40 misses", 0, 32'h0, 0, 32'h0);
    drive(0, 1, 1, 32'h40, 0, 0, 32'h0);
    chk_outs("rmiss 0x40 req", 0, 32'h0, 1, 32'h40);
    drive(0, 1, 1, 32'h40, 0, 1, 32'h77777777);
    chk_outs("rmiss 0x40 fill", 1, 32'h77777777, 1, 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
